pwm_duty_ramp: RTL
==================

Name: pwm_duty_ramp

Overview:
Soft-start/soft-stop duty-cycle sequencer that sits directly upstream of the PWM generator and drives its 7-bit percent duty input (0..100).
- Slews the applied duty toward a requested target by a fixed step per N PWM frames.
- Updates the duty only at PWM frame boundaries, so the generator never sees a mid-frame change.
- Provides an abort/fault path that forces duty to 0 immediately.

Parameters:
- PERIOD, 256, PWM frame length in clk cycles; matches the generator's 8-bit counter wrap; legal range >= 2.
- DC_MAX, 100, maximum duty in percent; target is clamped to this.
- STEP, 1, duty increment/decrement per step; legal range 1..DC_MAX.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  1 = ramp toward target_dc; 0 = ramp toward 0
- target_dc  in  7  requested duty, percent; values > DC_MAX are treated as DC_MAX
- rate  in  4  frames per step minus one; 0 = step every frame, 15 = step every 16 frames
- abort  in  1  synchronous kill request, level-sensitive
- dc  out  7  applied duty to the PWM generator
- frame_tick  out  1  high for one cycle on the last cycle of each frame
- busy  out  1  state is RAMP_UP or RAMP_DN
- at_target  out  1  dc == tgt_eff and fault == 0
- fault  out  1  abort latched

Behaviour:
- Reset (reset=0, async):
  - fcnt=0, rcnt=0, dc=0, state=IDLE, fault=0.
  - Hence frame_tick=0, busy=0, at_target=1.
- Frame counter fcnt:
  - Width clog2(PERIOD); free-running; increments every cycle; wraps PERIOD-1 -> 0.
  - frame_tick = (fcnt == PERIOD-1), decoded combinationally from the fcnt register.
  - First tick occurs on the cycle after the PERIOD-1'th rising edge following reset release.
- Effective target: tgt_eff = (en && !fault) ? min(target_dc, DC_MAX) : 0.
- States: IDLE, RAMP_UP, RAMP_DN, HOLD. Evaluated every cycle from registered dc and current tgt_eff:
  - tgt_eff > dc -> RAMP_UP.
  - tgt_eff < dc -> RAMP_DN.
  - tgt_eff == dc -> HOLD if dc != 0, otherwise IDLE.
- Step timing:
  - Steps occur only on frame_tick cycles while in a ramp state.
  - On such a cycle: if rcnt == rate, take a step and set rcnt=0; else rcnt++.
  - A new dc value is visible from the cycle where fcnt==0 (latency 1 cycle from the tick).
- Step arithmetic, no overshoot, computed at 8 bits to avoid overflow:
  - Up: dc <= min(dc+STEP, tgt_eff).
  - Down: dc <= (dc > tgt_eff+STEP) ? dc-STEP : tgt_eff.
- rcnt clears to 0 on any state change, including a direction reversal mid-ramp. The first step after a change therefore occurs rate+1 frame ticks later.
- Target or rate changes mid-ramp take effect at the next cycle's state evaluation; there is no restart of fcnt.
- Abort:
  - abort=1 has priority over everything except reset.
  - Next edge: dc=0, rcnt=0, state=IDLE, fault=1, regardless of frame position (safety overrides frame alignment).
  - fault holds dc at 0 until en=0 is observed with abort=0. fault clears on that edge.
  - A later en=1 then ramps from 0.
- Simultaneous abort and frame_tick: abort wins; no step is taken.
- Reset asserted mid-ramp: everything returns to reset values asynchronously; no frame alignment is preserved.
- dc is a register output, never combinational; it is always <= DC_MAX.

Decomposition:
- Shared package pwm_pkg holds:
  - DC_W=7 and DC_MAX=100 constants, shared with the PWM generator.
  - State enum ramp_state_t {IDLE, RAMP_UP, RAMP_DN, HOLD}.
- One natural sub-module: pwm_frame_timer (fcnt plus frame_tick). It is reusable by the generator so both share one frame reference.
- Step and clamp arithmetic stays inline.

Test Plan:
- PERIOD=8, STEP=1, rate=0, en=1, target_dc=3 -> dc changes 0->1->2->3 at 8-cycle spacing, each change visible at fcnt==0. busy=1 during the ramp; at 3, busy=0, at_target=1, state HOLD.
- PERIOD=8, STEP=10, rate=1, target_dc=127 -> clamps to 100. dc steps 10, 20, ..., 100 every 2 frames (16 cycles), with no value above 100.
- Ramp up to 50 (STEP=1, rate=0), then drive en=0 mid-ramp -> rcnt clears; dc decrements by 1 per frame to 0, then state IDLE, busy=0.
- STEP=7, dc=5, target 0 -> dc goes directly 5->0 with no underflow. Then target 3 with dc=0 -> dc 0->3 in one step (clamped, no overshoot).
- Assert abort for 1 cycle at fcnt=3 with dc=40 -> next cycle dc=0, fault=1. With en=1 held, dc stays 0 for 10 frames. After en=0 for 1 cycle, fault=0; en=1 restarts the ramp from 0.
- Assert reset asynchronously mid-cycle during a ramp -> dc=0, fault=0, fcnt=0 immediately. After release, first frame_tick occurs 8 cycles later (PERIOD=8).

Source files
------------

// File: rtl/pwm_pkg.sv
// Constants and state type shared between the duty ramp sequencer and the PWM generator.
package pwm_pkg;

    localparam int DC_W   = 7;
    localparam int DC_MAX = 100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2,
        HOLD    = 2'd3
    } ramp_state_t;

endpackage

// File: rtl/pwm_frame_timer.sv
// Free-running PWM frame counter; frame_tick marks the last cycle of each frame so that
// the generator and the duty sequencer share one frame reference.
module pwm_frame_timer #(
    parameter int PERIOD = 256
) (
    input  logic clk,
    input  logic reset,
    output logic o_frameTick
);

    localparam int CW = $clog2(PERIOD);

    logic [CW-1:0] r_fcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fcnt <= '0;
        end else if (r_fcnt == CW'(PERIOD - 1)) begin
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + CW'(1);
        end
    end

    assign o_frameTick = (r_fcnt == CW'(PERIOD - 1));

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start/soft-stop duty sequencer: slews the applied duty toward the requested target
// one step per (rate+1) frames, only at frame boundaries, with an immediate abort path.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int PERIOD = 256,
    parameter int DC_MAX = pwm_pkg::DC_MAX,
    parameter int STEP   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_en,
    input  logic [DC_W-1:0] i_targetDc,
    input  logic [3:0]      i_rate,
    input  logic            i_abort,
    output logic [DC_W-1:0] o_dc,
    output logic            o_frameTick,
    output logic            o_busy,
    output logic            o_atTarget,
    output logic            o_fault
);

    logic [DC_W-1:0] r_dc;
    logic [3:0]      r_rcnt;
    logic            r_fault;
    ramp_state_t     r_state;

    logic            w_frameTick;
    logic [DC_W-1:0] w_tgtClamped;
    logic [DC_W-1:0] w_tgtEff;
    ramp_state_t     w_state;
    logic [7:0]      w_dc8;
    logic [7:0]      w_tgt8;
    logic [7:0]      w_up8;
    logic [7:0]      w_upNext;
    logic [7:0]      w_dnNext;
    logic            w_ramping;
    logic            w_stepSlot;

    pwm_frame_timer #(
        .PERIOD (PERIOD)
    ) u_frameTimer (
        .clk         (clk),
        .reset       (reset),
        .o_frameTick (w_frameTick)
    );

    assign w_tgtClamped = (i_targetDc > DC_W'(DC_MAX)) ? DC_W'(DC_MAX) : i_targetDc;
    assign w_tgtEff     = (i_en && !r_fault) ? w_tgtClamped : '0;

    always_comb begin
        w_state = IDLE;
        if (w_tgtEff > r_dc) begin
            w_state = RAMP_UP;
        end else if (w_tgtEff < r_dc) begin
            w_state = RAMP_DN;
        end else if (r_dc != '0) begin
            w_state = HOLD;
        end
    end

    // 8-bit arithmetic so dc+STEP and tgt+STEP cannot wrap before the clamp.
    assign w_dc8    = {1'b0, r_dc};
    assign w_tgt8   = {1'b0, w_tgtEff};
    assign w_up8    = w_dc8 + 8'(STEP);
    assign w_upNext = (w_up8 > w_tgt8) ? w_tgt8 : w_up8;
    assign w_dnNext = (w_dc8 > (w_tgt8 + 8'(STEP))) ? (w_dc8 - 8'(STEP)) : w_tgt8;

    assign w_ramping  = (w_state == RAMP_UP) || (w_state == RAMP_DN);
    assign w_stepSlot = w_frameTick && w_ramping && (w_state == r_state);

    // A state change restarts the frame divider, and that cycle never steps even on a tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dc    <= '0;
            r_rcnt  <= '0;
            r_fault <= 1'b0;
            r_state <= IDLE;
        end else if (i_abort) begin
            r_dc    <= '0;
            r_rcnt  <= '0;
            r_fault <= 1'b1;
            r_state <= IDLE;
        end else begin
            r_state <= w_state;
            if (r_fault && !i_en) begin
                r_fault <= 1'b0;
            end
            if (w_state != r_state) begin
                r_rcnt <= '0;
            end else if (w_stepSlot) begin
                if (r_rcnt == i_rate) begin
                    r_rcnt <= '0;
                    r_dc   <= (w_state == RAMP_UP) ? w_upNext[DC_W-1:0] : w_dnNext[DC_W-1:0];
                end else begin
                    r_rcnt <= r_rcnt + 4'd1;
                end
            end
        end
    end

    assign o_dc        = r_dc;
    assign o_frameTick = w_frameTick;
    assign o_busy      = w_ramping;
    assign o_atTarget  = (r_dc == w_tgtEff) && !r_fault;
    assign o_fault     = r_fault;

endmodule
